// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: FSM encoding
// and the iteration counter width helper.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must hold 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// A/B/P/cnt registers, adder and shifters of the shift-and-add multiplier.
// SEQ_MUL_SIGNED_EN adds magnitude capture and a registered sign fix-up.
module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic                 fix,
`endif
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 b_next_zero,
    output logic                 cnt_last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] p_next;

`ifdef SEQ_MUL_SIGNED_EN
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    sign;

    assign a_s = a_in;
    assign b_s = b_in;
    // -(-2^(W-1)) wraps to the same bit pattern, which reads as 2^(W-1) unsigned.
    assign a_mag = a_s[WIDTH-1] ? WIDTH'(-a_s) : a_in;
    assign b_mag = b_s[WIDTH-1] ? WIDTH'(-b_s) : b_in;
    assign p_next = (fix && sign) ? (~sum + 1'b1) : sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sign <= 1'b0;
        else if (load)
            sign <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
    end
`else
    assign a_mag  = a_in;
    assign b_mag  = b_in;
    assign p_next = sum;
`endif

    assign sum = p_reg + (b_reg[0] ? a_reg : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
            cnt   <= '0;
        end else if (load) begin
            a_reg <= {{WIDTH{1'b0}}, a_mag};
            b_reg <= b_mag;
            p_reg <= '0;
            cnt   <= '0;
        end else if (step) begin
            p_reg <= p_next;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

    assign b_next_zero = (b_reg[WIDTH-1:1] == '0);
    assign cnt_last    = (cnt == CNT_MAX);
    assign product     = p_reg;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier with start/busy/done control.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands and product.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t state;
    state_t state_next;
    logic   load;
    logic   step;
    logic   b_next_zero;
    logic   cnt_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Operands are captured on the IDLE->LOAD edge, so load fires from IDLE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (b_next_zero || cnt_last)
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SEQ_MUL_SIGNED_EN
    logic fix;
    assign fix = step && (b_next_zero || cnt_last);
`endif

    seq_mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
`ifdef SEQ_MUL_SIGNED_EN
        .fix         (fix),
`endif
        .a_in        (a_in),
        .b_in        (b_in),
        .b_next_zero (b_next_zero),
        .cnt_last    (cnt_last),
        .product     (product)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: timeline-based reference model with a
// per-cycle compare process, plus hand-computed literal transactions.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endfunction

    // Iterations = position of highest set bit of |b| plus one, at least one.
    function automatic int calc_n(input logic [W-1:0] b);
        logic [W-1:0] m;
        int n;
`ifdef SEQ_MUL_SIGNED_EN
        m = b[W-1] ? -b : b;
`else
        m = b;
`endif
        n = 1;
        for (int i = 0; i < W; i++)
            if (m[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [2*W-1:0] calc_p(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MUL_SIGNED_EN
        logic signed [2*W-1:0] r;
        r = $signed(a) * $signed(b);
        return r;
`else
        return (2*W)'(a) * (2*W)'(b);
`endif
    endfunction

    // Reference model: one timeline per accepted request, indexed by clock edge.
    int             cyc = 0;
    bit             have_op = 1'b0;
    int             t0 = 0;
    int             n_exp = 1;
    logic [2*W-1:0] res_exp = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have_op <= 1'b0;
            res_exp <= '0;
        end else begin
            cyc <= cyc + 1;
            if (start && (!have_op || cyc + 1 >= t0 + n_exp + 3)) begin
                have_op <= 1'b1;
                t0      <= cyc + 1;
                n_exp   <= calc_n(b_in);
                res_exp <= calc_p(a_in, b_in);
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            check("busy", 32'(busy), 32'(have_op && cyc >= t0 && cyc <= t0 + n_exp));
            check("done", 32'(done), 32'(have_op && cyc == t0 + n_exp + 1));
            if (!have_op)
                check("product_idle", 32'(product), 32'(res_exp));
            else if (cyc == t0)
                check("product_load", 32'(product), 32'd0);
            else if (cyc >= t0 + n_exp + 1)
                check("product_result", 32'(product), 32'(res_exp));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_p, input int exp_lat, output int busy_n);
        int lat;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
        end
        check("op_timeout", 32'(done), 32'd1);
        check("op_latency", 32'(lat), 32'(exp_lat));
        check("op_product", 32'(product), 32'(exp_p));
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || done) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(busy || done), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int bn;
        bit first_seen;
        logic [W-1:0] ra, rb;

        rst   = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        run_cmp = 1'b1;

        run_op(8'd13, 8'd11, 16'd143, 6, bn);
        check("busy_13x11", 32'(bn), 32'd5);
        @(negedge clk);
        check("held_idle1", 32'(product), 32'd143);
        @(negedge clk);
        check("held_idle2", 32'(product), 32'd143);

`ifdef SEQ_MUL_SIGNED_EN
        run_op(8'hFD, 8'd5, 16'hFFF1, 5, bn);
        run_op(8'h80, 8'h80, 16'd16384, 10, bn);
        run_op(8'd127, 8'hFF, 16'hFF81, 3, bn);
`else
        run_op(8'd255, 8'd255, 16'd65025, 10, bn);
        check("busy_255x255", 32'(bn), 32'd9);
`endif
        run_op(8'd200, 8'd0, 16'd0, 3, bn);
        run_op(8'd1, 8'h80, calc_p(8'd1, 8'h80), 10, bn);
        run_op(8'd0, 8'd255, 16'd0, calc_n(8'd255) + 2, bn);

        // Continuous start with operands changing while busy.
        first_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done && !first_seen) begin
                first_seen = 1'b1;
                check("stream_first", 32'(product), 32'd15);
            end
            if (i == 0) begin
                a_in = 8'd3;
                b_in = 8'd5;
            end else begin
                a_in = W'($urandom);
                b_in = W'($urandom);
            end
            start = 1'b1;
        end
        start = 1'b0;
        check("stream_first_seen", 32'(first_seen), 32'd1);
        wait_idle();

        // Reset in the 3rd CALC cycle of a long operation.
        @(negedge clk);
`ifdef SEQ_MUL_SIGNED_EN
        a_in = 8'd127;
        b_in = 8'd127;
`else
        a_in = 8'd255;
        b_in = 8'd255;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd7, 8'd9, 16'd63, 6, bn);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom) & (8'hFF >> $urandom_range(0, 7));
            run_op(ra, rb, calc_p(ra, rb), calc_n(rb) + 2, bn);
            check("rand_busy", 32'(bn), 32'(calc_n(rb) + 1));
        end

        @(negedge clk);
        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-and-add multiplier with an integrated start/busy/done controller. It supersedes the fixed repeated-addition load/clear/decrement controller. Iteration count scales with the multiplier's highest set bit rather than its value. Product width is twice the operand width. The block sits behind any register-mapped or streaming front end that presents two operands and pulses `start`.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≥2.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: request; sampled only in IDLE.
- `a_in`  input  WIDTH: multiplicand; captured in the cycle `start` is accepted.
- `b_in`  input  WIDTH: multiplier; captured in the cycle `start` is accepted.
- `busy`  output  1: high in LOAD and CALC.
- `done`  output  1: high for exactly one cycle, in DONE.
- `product`  output  2*WIDTH: result register; valid from DONE and held until the next LOAD.

## Operation
- FSM states:
  - IDLE: `start`=1 → LOAD; otherwise stay in IDLE.
  - LOAD: capture operands. Set A = zero-extended a (2W bits), B = b, P = 0, cnt = 0. Go to CALC.
  - CALC: each cycle:
    - if B[0]: P ← P + A
    - A ← A<<1
    - B ← B>>1
    - cnt ← cnt+1
    - Go to DONE when (B>>1)==0 or cnt==WIDTH-1; otherwise stay in CALC.
  - DONE: `done`=1, go to IDLE unconditionally.
- Operands are captured from the inputs on the edge that takes IDLE → LOAD. Input changes after that edge have no effect.
- `start` is ignored in LOAD, CALC and DONE. No queueing.
- Arithmetic:
  - unsigned by default;
  - P and A are 2*WIDTH bits wide, and the sum never overflows;
  - cnt is $clog2(WIDTH) bits.
- b = 0: exactly one CALC cycle, product = 0.
- `product` drives P directly; it is not cleared in IDLE.
- Reset values: `busy`=0, `done`=0, `product`=0, state=IDLE, cnt=0.
- `rst` asserted in any state, including mid-CALC, aborts the operation immediately. No `done` is produced.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- Cycle after E0: LOAD, `busy`=1.
- Next N cycles: CALC, where N = max(1, position of the highest set bit of b_in, plus 1). N ≤ WIDTH.
- Then one DONE cycle with `done`=1, `busy`=0.
- Total latency from E0 to the `done` cycle: N+2 cycles.
- `start` held continuously high:
  - one accepted request per IDLE visit;
  - back-to-back throughput is one result every N+3 cycles.

## Configuration
- `SEQ_MUL_SIGNED_EN` defined: operands and product are two's complement.
  - LOAD stores |a|, |b| and sign = a[W-1]^b[W-1].
  - CALC runs on magnitudes, with N computed from |b|.
  - On the CALC→DONE edge, P ← −P if sign is set (registered); latency is unchanged.
  - −2^(WIDTH-1) is handled as magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
- `SEQ_MUL_SIGNED_EN` undefined: pure unsigned; no sign logic is synthesised.

## Structure
- Shared package `seq_mul_pkg`:
  - state encodings: IDLE=2'd0, LOAD=2'd1, CALC=2'd2, DONE=2'd3;
  - the width helper for cnt.
- One sub-module, `seq_mul_datapath`: A/B/P/cnt registers, adder, shifters, optional sign fix-up.
  - It exports `b_next_zero` and `cnt_last` to the FSM in the top level.
  - It takes load/step/fix enables from the FSM.

## Test plan
- WIDTH=8, a=13, b=11 → 4 CALC cycles; `done` pulses one cycle, 6 cycles after E0; `product`=143, held through IDLE.
- a=255, b=255 → 8 CALC cycles; `product`=65025; `busy` high for 9 cycles.
- a=200, b=0 → 1 CALC cycle; `product`=0; `done` 3 cycles after E0.
- `start` held high for 30 cycles, with a_in/b_in changing during `busy` (first request a=3, b=5):
  - results use only the operands captured at each accept;
  - exactly one `done` per operation;
  - a new operation starts on the first IDLE cycle;
  - first product is 15.
- `rst` pulsed during the 3rd CALC cycle of 255×255:
  - `busy`/`done`/`product` go to 0 asynchronously, with no `done`;
  - the next request 7×9 yields 63.
- With `SEQ_MUL_SIGNED_EN`:
  - −3×5 → 16'hFFF1;
  - −128×−128 → 16384;
  - 127×−1 → −127;
  - latencies match the magnitude-based N.
